fixed_divider: RTL and testbench

- Sequential radix-2 restoring divider for signed Q8.8 fixed point (scale 2^-8).
- It is the inverse datapath to the team's shift-add fixed multiplier and sits beside it in the FFT8 butterfly/normalisation path.
- Computes quot = dividend / divisor, truncated toward zero and saturated to the Q8.8 range.
- Uses a strobe-in / strobe-out handshake and a fixed latency.

---
 rtl/fixed_pkg.sv | 14 +
 rtl/fixed_abs.sv | 9 +
 rtl/fixed_divider.sv | 117 +++++++++++
 tb/tb_fixed_divider.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared signed Q8.8 fixed-point definitions for the divider and the shift-add multiplier.
package fixed_pkg;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int ITER  = WIDTH + FRAC;

  // Value of one LSB, used only when printing results as reals.
  localparam real SF = 1.0 / 256.0;

  localparam logic [WIDTH-1:0] Q_MAX     = 16'h7FFF;
  localparam logic [WIDTH-1:0] Q_MIN_SAT = 16'h8001;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/fixed_abs.sv
// Two's-complement to unsigned magnitude; the most negative input maps to 2^(W-1) without loss.
module fixed_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] mag_o
);
  assign mag_o = a_i[W-1] ? (~a_i + 1'b1) : a_i;
endmodule

// File: rtl/fixed_divider.sv
// Sequential radix-2 restoring divider for signed Q8.8, strobe-in/strobe-out, fixed latency.
// Define ROUND_NEAREST_EN for round-half-away-from-zero (one extra iteration); default truncates.
module fixed_divider #(
  parameter int WIDTH = fixed_pkg::WIDTH,
  parameter int FRAC  = fixed_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             in_stb,
  output logic             busy,
  output logic [WIDTH-1:0] quot,
  output logic             out_stb,
  output logic             ovf,
  output logic             dz
);
  import fixed_pkg::*;

`ifdef ROUND_NEAREST_EN
  localparam int SHIFT = FRAC + 1;
`else
  localparam int SHIFT = FRAC;
`endif
  localparam int NB = WIDTH + SHIFT;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0]    LAST    = CW'(NB - 1);
  localparam logic [WIDTH-1:0] MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state_q;
  logic             sign_q, zdiv_q, busy_q, out_stb_q, ovf_q, dz_q;
  logic [WIDTH-1:0] dvsr_q, rem_q, quot_q;
  logic [NB-1:0]    num_q, quo_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   rem_sh;
  logic             take;
  logic [WIDTH-1:0] rem_d, mag, quot_d;
  logic [NB-1:0]    mag_full;
  logic             sat;

  fixed_abs #(.W(WIDTH)) u_abs_dvd (.a_i(dividend), .mag_o(abs_dvd));
  fixed_abs #(.W(WIDTH)) u_abs_dvs (.a_i(divisor),  .mag_o(abs_dvs));

  always_comb begin
    rem_sh = {rem_q, num_q[NB-1]};
    take   = rem_sh >= {1'b0, dvsr_q};
    // Remainder stays below the divisor, so the top bit is dropped safely; with a zero divisor it is don't-care.
    rem_d  = take ? WIDTH'(rem_sh - {1'b0, dvsr_q}) : rem_sh[WIDTH-1:0];
`ifdef ROUND_NEAREST_EN
    mag_full = {1'b0, quo_q[NB-1:1]} + NB'(quo_q[0]);
`else
    mag_full = quo_q;
`endif
    sat    = zdiv_q || (mag_full > {{(NB-WIDTH){1'b0}}, MAG_MAX});
    mag    = sat ? MAG_MAX : mag_full[WIDTH-1:0];
    quot_d = sign_q ? -mag : mag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      zdiv_q    <= 1'b0;
      busy_q    <= 1'b0;
      out_stb_q <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      dvsr_q    <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      num_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      out_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_stb) begin
            sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dvsr_q  <= abs_dvs;
            zdiv_q  <= (divisor == '0);
            num_q   <= {abs_dvd, {SHIFT{1'b0}}};
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          num_q <= num_q << 1;
          quo_q <= {quo_q[NB-2:0], take};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          quot_q    <= quot_d;
          ovf_q     <= sat;
          dz_q      <= zdiv_q;
          out_stb_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign quot    = quot_q;
  assign out_stb = out_stb_q;
  assign ovf     = ovf_q;
  assign dz      = dz_q;
endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: vector table plus corner-case sequences, scoreboard on out_stb.
module tb_fixed_divider;
  import fixed_pkg::*;

`ifdef ROUND_NEAREST_EN
  localparam int LAT = 26;
  localparam logic [WIDTH-1:0] Q_TWO_THIRDS = 16'h00AB;
`else
  localparam int LAT = 25;
  localparam logic [WIDTH-1:0] Q_TWO_THIRDS = 16'h00AA;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             in_stb = 1'b0;
  logic             busy, out_stb, ovf, dz;
  logic [WIDTH-1:0] quot;

  fixed_divider dut (
    .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor), .in_stb(in_stb),
    .busy(busy), .quot(quot), .out_stb(out_stb), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic             o;
    logic             z;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             o;
    logic             z;
    int               due;
    string            nm;
  } exp_t;

  localparam int NV = 13;
  vec_t vt[NV];
  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Call at a negedge; waits for idle, drives one request through one accepting edge.
  task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] q, input logic o, input logic z,
                       input bit track, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) timeout({nm, "_idle"});
    dividend = a;
    divisor  = b;
    in_stb   = 1'b1;
    @(posedge clk);
    #1;
    in_stb = 1'b0;
    if (track) sb.push_back('{q: q, o: o, z: z, due: cyc + LAT, nm: nm});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      timeout({nm, "_drain"});
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && out_stb === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out_stb: got strobe with quot=%h want no strobe", quot);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_quot"}, 32'(quot), 32'(e.q));
        chk({e.nm, "_ovf"}, 32'(ovf), 32'(e.o));
        chk({e.nm, "_dz"}, 32'(dz), 32'(e.z));
        chk({e.nm, "_latency_cycle"}, cyc, e.due);
        $display("result %s = %f", e.nm, $itor($signed(quot)) * SF);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0};
    vt[1]  = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0};
    vt[2]  = '{16'h8000, 16'h8000, 16'h0100, 1'b0, 1'b0};
    vt[3]  = '{16'h0200, 16'h0300, Q_TWO_THIRDS, 1'b0, 1'b0};
    vt[4]  = '{16'h7F00, 16'h0080, Q_MAX, 1'b1, 1'b0};
    vt[5]  = '{16'hFF00, 16'h0000, Q_MIN_SAT, 1'b1, 1'b1};
    vt[6]  = '{16'h0000, 16'h0000, Q_MAX, 1'b1, 1'b1};
    vt[7]  = '{16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0};
    vt[8]  = '{16'h8000, 16'h0100, Q_MIN_SAT, 1'b1, 1'b0};
    vt[9]  = '{16'h0100, 16'hFF00, 16'hFF00, 1'b0, 1'b0};
    vt[10] = '{16'h7FFF, 16'h0001, Q_MAX, 1'b1, 1'b0};
    vt[11] = '{16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0};
    vt[12] = '{16'hFF80, 16'h0180, 16'hFFAB, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_quot", 32'(quot), 32'd0);
    chk("reset_out_stb", 32'(out_stb), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_dz", 32'(dz), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      start(vt[i].a, vt[i].b, vt[i].q, vt[i].o, vt[i].z, 1'b1, $sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
    end

    // A request while busy must be ignored without disturbing the running one.
    @(negedge clk);
    start(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b1, "busy_ignore");
    repeat (4) @(negedge clk);
    chk("busy_during_op", 32'(busy), 32'd1);
    dividend = 16'h0100;
    divisor  = 16'h0100;
    in_stb   = 1'b1;
    @(posedge clk);
    #1;
    in_stb = 1'b0;
    drain("busy_ignore");
    repeat (LAT + 5) @(negedge clk);

    // Back-to-back: the next request is presented during the out_stb cycle.
    @(negedge clk);
    start(16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 1'b1, "b2b_first");
    begin
      int n = 0;
      while (out_stb !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (out_stb !== 1'b1) timeout("b2b_strobe");
    end
    start(16'h0100, 16'hFF00, 16'hFF00, 1'b0, 1'b0, 1'b1, "b2b_second");
    drain("b2b_second");

    // Reset in the middle of an operation aborts it silently.
    @(negedge clk);
    start(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b0, "aborted");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_quot", 32'(quot), 32'd0);
    chk("midrst_out_stb", 32'(out_stb), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    start(16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b1, "after_reset");
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
